// File: rtl/data_mem_loader.sv
// Word-organised data RAM: port A serves the MEM stage, port B is fed by a little-endian
// byte-stream loader that exists only when DMEM_LOADER_EN is defined.
module data_mem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wr_byte_en,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rst,
    output logic [31:0] mem_rd_data,
    input  logic        ld_start,
    input  logic [31:0] ld_base_addr,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    // The preload image belongs to the RAM macro flow; the RTL array itself starts undefined.
    localparam bit HAS_IMAGE = (INIT_FILE != "");

    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   rd_q;
    logic [AW-1:0] a_idx_c;
    logic          a_we_c;
    logic [31:0]   a_merge_c;
    logic          unused_c;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign a_idx_c     = mem_addr[AW+1:2];
    assign a_we_c      = (mem_wr_byte_en != 4'b0000) && !Reset;
    assign a_merge_c   = merge_lanes(ram_q[a_idx_c], mem_wr_data, mem_wr_byte_en);
    assign mem_rd_data = rd_q;

`ifdef DMEM_LOADER_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} ld_state_e;

    ld_state_e     state_q;
    logic [AW-1:0] ptr_q;
    logic [1:0]    cnt_q;
    logic [3:0]    be_q;
    logic [31:0]   word_q;
    logic          last_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          collide_c;
    logic          b_we_c;
    logic [31:0]   b_merge_c;

    // Port A always wins a same-word write; the loader simply retries next cycle.
    assign collide_c = (mem_wr_byte_en != 4'b0000) && (a_idx_c == ptr_q);
    assign b_we_c    = (state_q == S_WRITE) && !collide_c && !Reset;
    assign b_merge_c = merge_lanes(ram_q[ptr_q], word_q, be_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= 2'd0;
            be_q    <= 4'b0000;
            word_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (ld_start) begin
                        ptr_q   <= ld_base_addr[AW+1:2];
                        cnt_q   <= 2'd0;
                        be_q    <= 4'b0000;
                        last_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (ld_valid && ready_q) begin
                        word_q[{cnt_q, 3'b000} +: 8] <= ld_byte;
                        be_q[cnt_q]                  <= 1'b1;
                        cnt_q                        <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3 || ld_last) begin
                            last_q  <= ld_last;
                            ready_q <= 1'b0;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (!collide_c) begin
                        ptr_q <= ptr_q + AW'(1);
                        cnt_q <= 2'd0;
                        be_q  <= 4'b0000;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ld_ready = ready_q;
    assign ld_busy  = busy_q;
    assign ld_done  = done_q;
    assign unused_c = ^{mem_addr[31:AW+2], mem_addr[1:0],
                        ld_base_addr[31:AW+2], ld_base_addr[1:0], HAS_IMAGE};
`else
    assign ld_ready = 1'b0;
    assign ld_busy  = 1'b0;
    assign ld_done  = 1'b0;
    assign unused_c = ^{mem_addr[31:AW+2], mem_addr[1:0], ld_start, ld_base_addr,
                        ld_valid, ld_last, ld_byte, HAS_IMAGE};
`endif

    // RAM array and read-first registered port A read.
    always_ff @(posedge Clk) begin
`ifdef DMEM_LOADER_EN
        if (b_we_c) ram_q[ptr_q] <= b_merge_c;
`endif
        if (a_we_c) ram_q[a_idx_c] <= a_merge_c;
        if (Reset || mem_rst) rd_q <= '0;
        else                  rd_q <= ram_q[a_idx_c];
    end

endmodule

// File: tb/tb_data_mem_loader.sv
// Scoreboard bench for data_mem_loader: port A reads checked by a negedge monitor against a word-array
// model; loader sessions exercised when DMEM_LOADER_EN is defined, tied-off outputs checked otherwise.
module tb_data_mem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wr_byte_en;
    logic [31:0] mem_wr_data;
    logic        mem_rst;
    logic [31:0] mem_rd_data;
    logic        ld_start;
    logic [31:0] ld_base_addr;
    logic        ld_valid;
    logic        ld_last;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;

    always #5 clk = ~clk;

    data_mem_loader #(.DEPTH(DEPTH)) dut (
        .Clk(clk), .Reset(rst),
        .mem_addr(mem_addr), .mem_wr_byte_en(mem_wr_byte_en), .mem_wr_data(mem_wr_data),
        .mem_rst(mem_rst), .mem_rd_data(mem_rd_data),
        .ld_start(ld_start), .ld_base_addr(ld_base_addr), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_byte(ld_byte),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          done_hi = 0;
    int          tag_n   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    int          tag_q [$];
    logic [7:0]  byte_q [$];
    logic        rd_issue = 1'b0;
    logic        rd_vld   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_issue;

    // Monitor: one expected word per issued port A access, compared when the read data appears.
    always @(negedge clk) begin
        if (ld_done) done_hi++;
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_underflow: got 0x%08h expected nothing", mem_rd_data);
            end else begin
                logic [31:0] e;
                int          t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk($sformatf("rd#%0d", t), mem_rd_data, e);
            end
        end
    end

    // One port A access; the model is read-first, so the expectation is taken before the write lands.
    task automatic porta(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                         input bit mrst, input bit chk_en);
        int idx;
        idx            = int'(addr[AW+1:2]);
        mem_addr       = addr;
        mem_wr_byte_en = be;
        mem_wr_data    = data;
        mem_rst        = mrst;
        rd_issue       = chk_en;
        if (chk_en) begin
            exp_q.push_back(mrst ? 32'h0 : model[idx]);
            tag_q.push_back(tag_n);
            tag_n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model[idx][8*i +: 8] = data[8*i +: 8];
        end
        @(negedge clk);
        mem_wr_byte_en = 4'h0;
        mem_rst        = 1'b0;
        rd_issue       = 1'b0;
    endtask

    task automatic readback(input int idx);
        porta(32'(idx * 4) | ($urandom << (AW + 2)), 4'h0, 32'h0, 1'b0, 1'b1);
    endtask

`ifdef DMEM_LOADER_EN
    task automatic send_byte(input logic [7:0] b, input bit last);
        int t;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        t = 0;
        while (!ld_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'(ld_ready), 32'h1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic ld_session(input logic [31:0] base, input int n, input bit collide, input bit gaps);
        int s0;
        int bidx;
        int t;
        s0   = done_hi;
        bidx = int'(base[AW+1:2]);
        // Start with a byte already valid: it must not be taken while still idle.
        ld_start     = 1'b1;
        ld_base_addr = base;
        ld_valid     = 1'b1;
        ld_byte      = 8'hEE;
        ld_last      = 1'b0;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("busy_after_start", 32'(ld_busy), 32'h1);
        chk("ready_in_collect", 32'(ld_ready), 32'h1);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(2) == 0) @(negedge clk);
            if (k == 1) begin
                ld_start     = 1'b1;
                ld_base_addr = base ^ 32'h200;
            end
            send_byte(byte_q[k], k == n - 1);
            ld_start = 1'b0;
        end
        if (collide) begin
            chk("ready_in_write", 32'(ld_ready), 32'h0);
            porta(32'(bidx * 4), 4'hF, $urandom, 1'b0, 1'b1);
        end
        t = 0;
        while (ld_busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("busy_cleared", 32'(ld_busy), 32'h0);
        chk("done_pulses", 32'(done_hi - s0), 32'h1);
        for (int k = 0; k < n; k++) begin
            model[(bidx + k / 4) % DEPTH][8*(k % 4) +: 8] = byte_q[k];
        end
        for (int w = 0; w < (n + 3) / 4; w++) readback((bidx + w) % DEPTH);
        byte_q.delete();
    endtask

    task automatic fill_bytes(input int n);
        for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom));
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mem_addr       = 32'h0;
        mem_wr_byte_en = 4'h0;
        mem_wr_data    = 32'h0;
        mem_rst        = 1'b0;
        ld_start       = 1'b0;
        ld_base_addr   = 32'h0;
        ld_valid       = 1'b0;
        ld_last        = 1'b0;
        ld_byte        = 8'h0;
        repeat (2) @(negedge clk);
        chk("reset_rd_data", mem_rd_data, 32'h0);
        chk("reset_ld_busy", 32'(ld_busy), 32'h0);
        chk("reset_ld_ready", 32'(ld_ready), 32'h0);
        chk("reset_ld_done", 32'(ld_done), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) porta(32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0);

        // Byte-lane merge and address wrap.
        porta(32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
        porta(32'h10, 4'h4, 32'h00AA0000, 1'b0, 1'b1);
        porta(32'h10, 4'h0, 32'h0, 1'b0, 1'b1);
        porta(32'h10 + 32'(4 * DEPTH), 4'h0, 32'h0, 1'b0, 1'b1);
        // Read-during-write returns the old word.
        porta(32'h20, 4'hF, 32'h0, 1'b0, 1'b1);
        porta(32'h20, 4'hF, 32'h12345678, 1'b0, 1'b1);
        porta(32'h20, 4'h0, 32'h0, 1'b0, 1'b1);
        porta(32'h20, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
        porta(32'h20, 4'h0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            porta($urandom, ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0, $urandom,
                  $urandom_range(15) == 0, 1'b1);
        end

`ifdef DMEM_LOADER_EN
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        ld_session(32'h40, 6, 1'b0, 1'b0);
        fill_bytes(5);
        ld_session(32'h103, 5, 1'b0, 1'b1);
        fill_bytes(6);
        ld_session(32'(4 * (DEPTH - 1)), 6, 1'b0, 1'b1);
        fill_bytes(4);
        ld_session(32'h80, 4, 1'b1, 1'b0);
        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 9);
            fill_bytes(n);
            ld_session($urandom & 32'hFFFF_FFFC, n, 1'b0, 1'b1);
        end
        begin : reset_mid_session
            int s0;
            s0 = done_hi;
            fill_bytes(2);
            ld_start     = 1'b1;
            ld_base_addr = 32'h300;
            @(negedge clk);
            ld_start = 1'b0;
            send_byte(byte_q[0], 1'b0);
            send_byte(byte_q[1], 1'b0);
            byte_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rd_after_reset", mem_rd_data, 32'h0);
            chk("busy_after_reset", 32'(ld_busy), 32'h0);
            chk("ready_after_reset", 32'(ld_ready), 32'h0);
            repeat (5) @(negedge clk);
            chk("no_done_after_reset", 32'(done_hi - s0), 32'h0);
            readback(32'h300 / 4);
        end
`else
        for (int i = 0; i < 20; i++) begin
            ld_start     = 1'($urandom);
            ld_valid     = 1'($urandom);
            ld_last      = 1'($urandom);
            ld_byte      = 8'($urandom);
            ld_base_addr = 32'h40;
            @(negedge clk);
            chk("ld_outputs_off", 32'({ld_ready, ld_busy, ld_done}), 32'h0);
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        readback(16);
        readback(17);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
